rst_gen: RTL and testbench

Reset pulse generator for the async FIFO reset tree: the source end of the reset that each clock domain's two-flop reset synchroniser consumes. It turns a power-on release or a single-cycle software flush request into a clean, registered, active-low reset pulse of guaranteed minimum width. After the pulse it enforces a guard interval and signals completion. It also provides the same ATPG bypass as the downstream synchronisers.

---
 rtl/fifo_rst_pkg.sv | 14 +
 rtl/rst_gen.sv | 104 ++++++++++
 tb/tb_rst_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fifo_rst_pkg.sv
// Shared definitions for the FIFO reset tree: reset-generator state encodings
// and default pulse/guard lengths.
package fifo_rst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GUARD  = 2'd2
  } rst_state_e;

  localparam int DEF_PULSE_CYCLES = 16;
  localparam int DEF_GUARD_CYCLES = 4;

endpackage

// File: rtl/rst_gen.sv
// Reset pulse generator: turns power-on release or a software flush request into
// a registered active-low pulse of PULSE_CYCLES, then a GUARD_CYCLES guard and a done pulse.
module rst_gen
  import fifo_rst_pkg::*;
#(
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic atpg_mode,
  input  logic sw_rst_req,
  output logic rst_out_n,
  output logic busy,
  output logic done
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             rst_out_q, rst_out_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    rst_out_d = rst_out_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sw_rst_req) begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          rst_out_d = 1'b0;
        end
      end
      ST_ASSERT: begin
        if (sw_rst_req) pend_d = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          state_d   = ST_GUARD;
          cnt_d     = '0;
          rst_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          done_d = 1'b1;
          cnt_d  = '0;
          // A request landing on the final guard edge restarts directly, like a pending one.
          if (pend_q || sw_rst_req) begin
            state_d   = ST_ASSERT;
            pend_d    = 1'b0;
            rst_out_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (sw_rst_req) pend_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        pend_d    = 1'b0;
        rst_out_d = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      rst_out_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // DFT bypass: the only combinational path to rst_out_n, and only from rst_n.
  assign rst_out_n = atpg_mode ? rst_n : rst_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rst_gen.sv
// Directed bench for rst_gen: default instance (16/4) and a minimum-parameter
// instance (2/1), checked against a small cycle model of pulse/guard timing.
module tb_rst_gen;

  localparam int P  = 16;
  localparam int G  = 4;
  localparam int L  = P + G;
  localparam int PS = 2;
  localparam int GS = 1;
  localparam int LS = PS + GS;

  logic clk;
  logic rst_n, atpg_mode, sw_rst_req;
  logic rst_out_n, busy, done;
  logic rst_n_s, sw_rst_req_s;
  logic rst_out_n_s, busy_s, done_s;

  int n_checks;
  int n_fail;

  rst_gen u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .atpg_mode (atpg_mode),
    .sw_rst_req(sw_rst_req),
    .rst_out_n (rst_out_n),
    .busy      (busy),
    .done      (done)
  );

  rst_gen #(.PULSE_CYCLES(PS), .GUARD_CYCLES(GS)) u_small (
    .clk       (clk),
    .rst_n     (rst_n_s),
    .atpg_mode (1'b0),
    .sw_rst_req(sw_rst_req_s),
    .rst_out_n (rst_out_n_s),
    .busy      (busy_s),
    .done      (done_s)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs from edge j_start to j_end, driving sw_rst_req from req_mask[j] before edge j.
  // Model: n_ev back-to-back events of length L; each is P low cycles then G high.
  task automatic run_chain(input string tag, input int j_start, input int j_end,
                           input logic [63:0] req_mask, input int n_ev);
    logic exp_rst, exp_done, exp_busy;
    for (int j = j_start; j <= j_end; j++) begin
      sw_rst_req = req_mask[j];
      tick();
      sw_rst_req = 1'b0;
      exp_busy = (j < n_ev * L);
      exp_rst  = (j >= n_ev * L) ? 1'b1 : ((j % L) >= P);
      exp_done = (j > 0) && (j % L == 0) && (j <= n_ev * L);
      check_eq($sformatf("%s rst_out_n j=%0d", tag, j), {31'b0, rst_out_n}, {31'b0, exp_rst});
      check_eq($sformatf("%s busy j=%0d", tag, j), {31'b0, busy}, {31'b0, exp_busy});
      check_eq($sformatf("%s done j=%0d", tag, j), {31'b0, done}, {31'b0, exp_done});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, " rst_out_n"}, {31'b0, rst_out_n}, 32'd0);
    check_eq({tag, " busy"}, {31'b0, busy}, 32'd1);
    check_eq({tag, " done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    rst_n_s      = 1'b0;
    atpg_mode    = 1'b0;
    sw_rst_req   = 1'b0;
    sw_rst_req_s = 1'b0;

    // Power-on: reset state, then automatic pulse and guard
    repeat (3) tick();
    check_reset_state("por_reset");
    rst_n   = 1'b1;
    rst_n_s = 1'b1;
    run_chain("por", 1, L + 3, 64'd0, 1);

    // Single request from IDLE
    run_chain("req1", 0, L + 3, 64'h1, 1);

    // Three requests during ASSERT coalesce into one extra pulse
    run_chain("coal", 0, 2 * L + 3, 64'h0000_0000_0000_0229, 2);

    // Request during GUARD and request exactly on the final guard edge
    run_chain("guardreq", 0, 2 * L + 3, (64'h1 << 18) | 64'h1, 2);
    run_chain("lastedge", 0, 2 * L + 3, (64'h1 << 20) | 64'h1, 2);

    // rst_n during ASSERT at cnt = 7 with a pending request
    run_chain("mid_a", 0, 7, 64'h5, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("mid_a async");
    repeat (2) tick();
    rst_n = 1'b1;
    run_chain("mid_a post", 1, L + 3, 64'd0, 1);

    // rst_n during GUARD at cnt = 2 with a pending request
    run_chain("mid_g", 0, P + 2, 64'h9, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("mid_g async");
    repeat (2) tick();
    rst_n = 1'b1;
    run_chain("mid_g post", 1, L + 3, 64'd0, 1);

    // ATPG bypass: rst_out_n follows rst_n with no clock
    atpg_mode = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_eq("atpg low", {31'b0, rst_out_n}, 32'd0);
    #1 rst_n = 1'b1;
    #1 check_eq("atpg high", {31'b0, rst_out_n}, 32'd1);
    for (int j = 1; j <= 5; j++) begin
      tick();
      check_eq($sformatf("atpg assert rst_out_n j=%0d", j), {31'b0, rst_out_n}, 32'd1);
      check_eq($sformatf("atpg assert busy j=%0d", j), {31'b0, busy}, 32'd1);
    end
    atpg_mode = 1'b0;
    #1 check_eq("atpg off rst_out_n", {31'b0, rst_out_n}, 32'd0);
    run_chain("atpg post", 6, L + 3, 64'd0, 1);

    // Minimum parameters: power-on, then a held request gives 2 low / 1 high
    rst_n_s = 1'b0;
    tick();
    check_eq("small reset rst_out_n", {31'b0, rst_out_n_s}, 32'd0);
    check_eq("small reset busy", {31'b0, busy_s}, 32'd1);
    rst_n_s = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check_eq($sformatf("small por rst_out_n j=%0d", j), {31'b0, rst_out_n_s}, {31'b0, (j >= PS)});
      check_eq($sformatf("small por done j=%0d", j), {31'b0, done_s}, {31'b0, (j == LS)});
      check_eq($sformatf("small por busy j=%0d", j), {31'b0, busy_s}, {31'b0, (j < LS)});
    end
    sw_rst_req_s = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      tick();
      check_eq($sformatf("small held rst_out_n j=%0d", j), {31'b0, rst_out_n_s}, {31'b0, ((j % LS) >= PS)});
      check_eq($sformatf("small held done j=%0d", j), {31'b0, done_s}, {31'b0, (j > 0 && j % LS == 0)});
      check_eq($sformatf("small held busy j=%0d", j), {31'b0, busy_s}, 32'd1);
    end
    sw_rst_req_s = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
